// File: rtl/cr_mc_fifo_wrap.sv
// Multi-channel FIFO: N_CHANNELS logical queues statically partitioned in one
// shared storage array, one write and one read per cycle, registered read data.
module cr_mc_fifo_wrap #(
   parameter  int N_DATA_BITS  = 64,
   parameter  int N_CHANNELS   = 4,
   parameter  int N_ENTRIES    = 8,
   parameter  int N_AFULL_VAL  = 1,
   parameter  int N_AEMPTY_VAL = 1,
   localparam int CH_W         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
   localparam int CNT_W        = $clog2(N_ENTRIES + 1)
) (
   input  logic                        clk_sys,
   input  logic                        rst,
   input  logic                        wen,
   input  logic [CH_W-1:0]             wch,
   input  logic [N_DATA_BITS-1:0]      wdata,
   input  logic                        ren,
   input  logic [CH_W-1:0]             rch,
   input  logic                        clr_err,
   output logic [N_DATA_BITS-1:0]      rdata,
   output logic                        rvalid,
   output logic [N_CHANNELS-1:0]       full,
   output logic [N_CHANNELS-1:0]       afull,
   output logic [N_CHANNELS-1:0]       empty,
   output logic [N_CHANNELS-1:0]       aempty,
   output logic [N_CHANNELS*CNT_W-1:0] used_slots,
   output logic [N_CHANNELS-1:0]       overflow,
   output logic [N_CHANNELS-1:0]       underflow
);

   localparam int PTR_W  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   localparam int DEPTH  = N_CHANNELS * N_ENTRIES;
   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [N_DATA_BITS-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]       wptr_q [N_CHANNELS];
   logic [PTR_W-1:0]       wptr_d [N_CHANNELS];
   logic [PTR_W-1:0]       rptr_q [N_CHANNELS];
   logic [PTR_W-1:0]       rptr_d [N_CHANNELS];
   logic [CNT_W-1:0]       used_q [N_CHANNELS];
   logic [CNT_W-1:0]       used_d [N_CHANNELS];
   logic [N_DATA_BITS-1:0] rdata_q, rdata_d;
   logic                   rvalid_q, rvalid_d;
   logic [N_CHANNELS-1:0]  ovf_q, ovf_d;
   logic [N_CHANNELS-1:0]  unf_q, unf_d;

   logic              wch_ok, rch_ok;
   logic              wr_full, rd_empty;
   logic              wr_acc, rd_acc;
   logic [ADDR_W-1:0] waddr, raddr;

   // Depth need not be a power of two, so wrap on an explicit compare.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(N_ENTRIES - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wch_ok   = int'(wch) < N_CHANNELS;
      rch_ok   = int'(rch) < N_CHANNELS;
      wr_full  = 1'b0;
      rd_empty = 1'b0;
      waddr    = '0;
      raddr    = '0;
      if (wch_ok) begin
         wr_full = (used_q[wch] == CNT_W'(N_ENTRIES));
         waddr   = ADDR_W'(int'(wch) * N_ENTRIES + int'(wptr_q[wch]));
      end
      if (rch_ok) begin
         rd_empty = (used_q[rch] == '0);
         raddr    = ADDR_W'(int'(rch) * N_ENTRIES + int'(rptr_q[rch]));
      end
      wr_acc = wen && wch_ok && !wr_full;
      rd_acc = ren && rch_ok && !rd_empty;
   end

   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         wptr_d[c] = wptr_q[c];
         rptr_d[c] = rptr_q[c];
         used_d[c] = used_q[c];
         if (wr_acc && int'(wch) == c) begin
            wptr_d[c] = ptr_inc(wptr_q[c]);
         end
         if (rd_acc && int'(rch) == c) begin
            rptr_d[c] = ptr_inc(rptr_q[c]);
         end
         used_d[c] = used_q[c]
                   + CNT_W'(wr_acc && int'(wch) == c)
                   - CNT_W'(rd_acc && int'(rch) == c);
      end

      rdata_d  = rd_acc ? mem_q[raddr] : rdata_q;
      rvalid_d = rd_acc;

      // A new error in the same cycle as clr_err must survive the clear.
      ovf_d = clr_err ? '0 : ovf_q;
      unf_d = clr_err ? '0 : unf_q;
      if (wen && wch_ok && wr_full) begin
         ovf_d[wch] = 1'b1;
      end
      if (ren && rch_ok && rd_empty) begin
         unf_d[rch] = 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            wptr_q[c] <= '0;
            rptr_q[c] <= '0;
            used_q[c] <= '0;
         end
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         ovf_q    <= '0;
         unf_q    <= '0;
      end else begin
         for (int c = 0; c < N_CHANNELS; c++) begin
            wptr_q[c] <= wptr_d[c];
            rptr_q[c] <= rptr_d[c];
            used_q[c] <= used_d[c];
         end
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is not reset; a write pending during reset is discarded.
   always_ff @(posedge clk_sys) begin
      if (!rst && wr_acc) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      for (int c = 0; c < N_CHANNELS; c++) begin
         full[c]   = (used_q[c] == CNT_W'(N_ENTRIES));
         empty[c]  = (used_q[c] == '0);
         afull[c]  = (N_ENTRIES - int'(used_q[c])) <= N_AFULL_VAL;
         aempty[c] = int'(used_q[c]) <= N_AEMPTY_VAL;
         used_slots[c*CNT_W +: CNT_W] = used_q[c];
      end
   end

   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_cr_mc_fifo_wrap.sv
// Bench for cr_mc_fifo_wrap: an 8-deep and a 5-deep instance, directed stimulus,
// read data checked by a scoreboard monitor, flags checked after each operation.
module tb_cr_mc_fifo_wrap;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0: 4 channels x 8 entries
   logic        rst0, wen0, ren0, clr0;
   logic [1:0]  wch0, rch0;
   logic [63:0] wdata0, rdata0;
   logic        rvalid0;
   logic [3:0]  full0, afull0, empty0, aempty0, ovf0, unf0;
   logic [15:0] used0;

   // instance 1: 4 channels x 5 entries
   logic        rst1, wen1, ren1, clr1;
   logic [1:0]  wch1, rch1;
   logic [63:0] wdata1, rdata1;
   logic        rvalid1;
   logic [3:0]  full1, afull1, empty1, aempty1, ovf1, unf1;
   logic [11:0] used1;

   cr_mc_fifo_wrap #(.N_DATA_BITS(64), .N_CHANNELS(4), .N_ENTRIES(8),
                     .N_AFULL_VAL(1), .N_AEMPTY_VAL(1)) dut0 (
      .clk_sys(clk), .rst(rst0), .wen(wen0), .wch(wch0), .wdata(wdata0),
      .ren(ren0), .rch(rch0), .clr_err(clr0), .rdata(rdata0), .rvalid(rvalid0),
      .full(full0), .afull(afull0), .empty(empty0), .aempty(aempty0),
      .used_slots(used0), .overflow(ovf0), .underflow(unf0));

   cr_mc_fifo_wrap #(.N_DATA_BITS(64), .N_CHANNELS(4), .N_ENTRIES(5),
                     .N_AFULL_VAL(1), .N_AEMPTY_VAL(1)) dut1 (
      .clk_sys(clk), .rst(rst1), .wen(wen1), .wch(wch1), .wdata(wdata1),
      .ren(ren1), .rch(rch1), .clr_err(clr1), .rdata(rdata1), .rvalid(rvalid1),
      .full(full1), .afull(afull1), .empty(empty1), .aempty(aempty1),
      .used_slots(used1), .overflow(ovf1), .underflow(unf1));

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q0 [$];
   logic [63:0] exp_q1 [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // read-data scoreboard monitor
   always @(negedge clk) begin
      logic [63:0] e;
      if (rvalid0 === 1'b1) begin
         n_checks++;
         if (exp_q0.size() == 0) begin
            n_fail++;
            $display("FAIL dut0_rdata: unexpected rvalid with rdata %0h", rdata0);
         end else begin
            e = exp_q0.pop_front();
            if (rdata0 !== e) begin
               n_fail++;
               $display("FAIL dut0_rdata: got %0h expected %0h", rdata0, e);
            end
         end
      end
      if (rvalid1 === 1'b1) begin
         n_checks++;
         if (exp_q1.size() == 0) begin
            n_fail++;
            $display("FAIL dut1_rdata: unexpected rvalid with rdata %0h", rdata1);
         end else begin
            e = exp_q1.pop_front();
            if (rdata1 !== e) begin
               n_fail++;
               $display("FAIL dut1_rdata: got %0h expected %0h", rdata1, e);
            end
         end
      end
   end

   task automatic idle_all();
      rst0 = 0; wen0 = 0; ren0 = 0; clr0 = 0; wch0 = 0; rch0 = 0; wdata0 = 0;
      rst1 = 0; wen1 = 0; ren1 = 0; clr1 = 0; wch1 = 0; rch1 = 0; wdata1 = 0;
   endtask

   task automatic op(input int d, input bit we, input int wc, input logic [63:0] wd,
                     input bit re, input int rc, input bit ce, input bit rs);
      if (d == 0) begin
         wen0 = we; wch0 = 2'(wc); wdata0 = wd; ren0 = re; rch0 = 2'(rc); clr0 = ce; rst0 = rs;
      end else begin
         wen1 = we; wch1 = 2'(wc); wdata1 = wd; ren1 = re; rch1 = 2'(rc); clr1 = ce; rst1 = rs;
      end
      @(posedge clk);
      #1;
      idle_all();
   endtask

   task automatic wr(input int d, input int ch, input logic [63:0] data);
      op(d, 1, ch, data, 0, 0, 0, 0);
   endtask

   task automatic rd(input int d, input int ch, input logic [63:0] exp);
      if (d == 0) exp_q0.push_back(exp);
      else        exp_q1.push_back(exp);
      op(d, 0, 0, 0, 1, ch, 0, 0);
   endtask

   function automatic logic [3:0] u0(input int c);
      return used0[c*4 +: 4];
   endfunction

   function automatic logic [2:0] u1(input int c);
      return used1[c*3 +: 3];
   endfunction

   initial begin
      idle_all();
      rst0 = 1; rst1 = 1;
      repeat (2) @(posedge clk);
      #1;
      idle_all();

      chk("rst_empty", empty0, 4'hF);
      chk("rst_aempty", aempty0, 4'hF);
      chk("rst_full", full0, 4'h0);
      chk("rst_afull", afull0, 4'h0);
      chk("rst_used", used0, 16'h0);
      chk("rst_rvalid", rvalid0, 1'b0);
      chk("rst_rdata", rdata0, 64'h0);
      chk("rst_err", {ovf0, unf0}, 8'h0);
      chk("rst_empty_d1", empty1, 4'hF);

      // fill and drain ch2
      for (int i = 0; i < 8; i++) begin
         wr(0, 2, 64'h10 + 64'(i));
         if (i == 0) chk("fill_aempty_1", aempty0[2], 1'b1);
         if (i == 1) chk("fill_aempty_2", aempty0[2], 1'b0);
         if (i == 5) chk("fill_afull_6", afull0[2], 1'b0);
         if (i == 6) begin
            chk("fill_afull_7", afull0[2], 1'b1);
            chk("fill_full_7", full0[2], 1'b0);
         end
      end
      chk("fill_full_8", full0, 4'b0100);
      chk("fill_used_8", u0(2), 4'd8);
      chk("fill_empty_8", empty0, 4'b1011);
      for (int i = 0; i < 8; i++) rd(0, 2, 64'h10 + 64'(i));
      chk("drain_empty", empty0, 4'hF);
      chk("drain_used", u0(2), 4'd0);

      // overflow while popping the same channel
      for (int i = 0; i < 8; i++) wr(0, 1, 64'h20 + 64'(i));
      chk("ovf_pre_full", full0[1], 1'b1);
      exp_q0.push_back(64'h20);
      op(0, 1, 1, 64'hDEAD, 1, 1, 0, 0);
      chk("ovf_flag", ovf0, 4'b0010);
      chk("ovf_used", u0(1), 4'd7);
      chk("ovf_unf", unf0, 4'b0000);
      op(0, 0, 0, 0, 0, 0, 1, 0);
      chk("ovf_clr", ovf0, 4'b0000);
      for (int i = 1; i < 8; i++) rd(0, 1, 64'h20 + 64'(i));
      chk("ovf_drained", empty0[1], 1'b1);

      // underflow with concurrent write on the same channel
      op(0, 1, 3, 64'h33, 1, 3, 0, 0);
      chk("unf_rvalid", rvalid0, 1'b0);
      chk("unf_flag", unf0, 4'b1000);
      chk("unf_used", u0(3), 4'd1);
      // write ch0 while reading ch3
      exp_q0.push_back(64'h33);
      op(0, 1, 0, 64'h40, 1, 3, 0, 0);
      chk("indep_used0", u0(0), 4'd1);
      chk("indep_used3", u0(3), 4'd0);
      chk("unf_sticky", unf0, 4'b1000);
      op(0, 0, 0, 0, 0, 0, 1, 0);
      chk("unf_clr", unf0, 4'b0000);

      // reset mid-traffic, then clr_err collision
      wr(0, 0, 64'h41);
      wr(0, 0, 64'h42);
      chk("mid_used", u0(0), 4'd3);
      op(0, 1, 0, 64'h99, 1, 0, 0, 1);
      chk("mid_empty", empty0, 4'hF);
      chk("mid_used_all", used0, 16'h0);
      chk("mid_rvalid", rvalid0, 1'b0);
      op(0, 0, 0, 0, 1, 1, 0, 0);
      chk("col_pre", unf0, 4'b0010);
      op(0, 0, 0, 0, 1, 0, 1, 0);
      chk("col_set_wins", unf0, 4'b0001);

      // non-power-of-two depth wrap on the 5-deep instance
      for (int i = 0; i < 3; i++) wr(1, 0, 64'h50 + 64'(i));
      for (int i = 0; i < 3; i++) rd(1, 0, 64'h50 + 64'(i));
      chk("wrap_empty", empty1[0], 1'b1);
      for (int i = 0; i < 5; i++) begin
         wr(1, 0, 64'h60 + 64'(i));
         if (i == 3) chk("wrap_full_4", full1[0], 1'b0);
      end
      chk("wrap_full_5", full1, 4'b0001);
      chk("wrap_used", u1(0), 3'd5);
      wr(1, 0, 64'h6F);
      chk("wrap_ovf", ovf1, 4'b0001);
      for (int i = 0; i < 5; i++) rd(1, 0, 64'h60 + 64'(i));
      chk("wrap_drained", empty1[0], 1'b1);

      repeat (2) @(posedge clk);
      #1;
      chk("sb_drained0", 64'(exp_q0.size()), 64'd0);
      chk("sb_drained1", 64'(exp_q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
